// File: rtl/pcie_us_cfg_poll.sv
// pcie_us_cfg_poll: round-robin poller of PF/VF config space over the
// UltraScale cfg_mgmt port. Per function it reads Command and Device Control,
// plus Link Control/Status for function index 0, and exports the decoded fields.
// Optional host write path through the same port: define PCIE_US_CFG_POLL_WRITE_EN.
//
// state          | meaning
// ST_IDLE        | poll interval countdown, or launch a host write
// ST_RD_CMD      | Command register read outstanding
// ST_RD_DEVCTRL  | Device Control read (issue cycle, then outstanding)
// ST_RD_LINK     | Link Control/Status read (function index 0 only)
// ST_WR          | host write outstanding
module pcie_us_cfg_poll #(
    parameter int          PF_COUNT         = 1,
    parameter int          VF_COUNT         = 0,
    parameter int          VF_OFFSET        = 64,
    parameter int          F_COUNT          = PF_COUNT + VF_COUNT,
    parameter logic [11:0] PCIE_CAP_OFFSET  = 12'h0C0,
    parameter int          POLL_INTERVAL    = 256,
    parameter int          TIMEOUT          = 1024,
    parameter int          READ_LINK_STATUS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef PCIE_US_CFG_POLL_WRITE_EN
    input  logic                   wr_req,
    input  logic [7:0]             wr_func,
    input  logic [9:0]             wr_addr,
    input  logic [31:0]            wr_data,
    input  logic [3:0]             wr_be,
    output logic                   wr_ack,
`endif
    output logic [F_COUNT-1:0]     ext_tag_enable,
    output logic [F_COUNT*3-1:0]   max_read_request_size,
    output logic [F_COUNT*3-1:0]   max_payload_size,
    output logic [F_COUNT-1:0]     bus_master_enable,
    output logic [3:0]             link_speed,
    output logic [5:0]             link_width,
    output logic [F_COUNT-1:0]     cfg_valid,
    output logic [7:0]             timeout_count,
    output logic [9:0]             cfg_mgmt_addr,
    output logic [7:0]             cfg_mgmt_function_number,
    output logic                   cfg_mgmt_write,
    output logic [31:0]            cfg_mgmt_write_data,
    output logic [3:0]             cfg_mgmt_byte_enable,
    output logic                   cfg_mgmt_read,
    input  logic [31:0]            cfg_mgmt_read_data,
    input  logic                   cfg_mgmt_read_write_done
);

    localparam int IDX_W = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
    localparam int DLY_W = $clog2(POLL_INTERVAL);
    localparam int TO_W  = $clog2(TIMEOUT);

    localparam logic [DLY_W-1:0] DLY_LOAD     = DLY_W'(POLL_INTERVAL - 1);
    localparam logic [TO_W-1:0]  TO_LOAD      = TO_W'(TIMEOUT - 1);
    localparam logic [9:0]       ADDR_CMD     = 10'd1;
    localparam logic [11:0]      BYTE_DEVCTRL = PCIE_CAP_OFFSET + 12'd8;
    localparam logic [11:0]      BYTE_LINK    = PCIE_CAP_OFFSET + 12'd16;
    localparam logic [9:0]       ADDR_DEVCTRL = BYTE_DEVCTRL[11:2];
    localparam logic [9:0]       ADDR_LINK    = BYTE_LINK[11:2];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CMD,
        ST_RD_DEVCTRL,
        ST_RD_LINK,
        ST_WR
    } state_t;

    // PFs map straight through; VFs start at VF_OFFSET.
    function automatic logic [7:0] func_num(input logic [IDX_W-1:0] idx);
        int i;
        i = int'(idx);
        if (i < PF_COUNT) return 8'(i);
        return 8'(VF_OFFSET + i - PF_COUNT);
    endfunction

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DLY_W-1:0]       dly_q, dly_d;
    logic [TO_W-1:0]        to_q, to_d;
    logic                   rd_q, rd_d;
    logic [9:0]             addr_q, addr_d;
    logic [7:0]             fn_q, fn_d;
    logic [F_COUNT-1:0]     bme_q, bme_d;
    logic [F_COUNT-1:0]     ext_q, ext_d;
    logic [F_COUNT*3-1:0]   mrrs_q, mrrs_d;
    logic [F_COUNT*3-1:0]   mps_q, mps_d;
    logic [3:0]             speed_q, speed_d;
    logic [5:0]             width_q, width_d;
    logic [F_COUNT-1:0]     valid_q, valid_d;
    logic [7:0]             tcnt_q, tcnt_d;
    logic                   end_poll, end_ok;
    logic [F_COUNT-1:0]     sel;
    logic                   unused_rd_data;

`ifdef PCIE_US_CFG_POLL_WRITE_EN
    logic                   wr_q, wr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic                   ack_q, ack_d;
`endif

    assign unused_rd_data = ^cfg_mgmt_read_data;

    // One-hot select of the function currently being polled.
    always_comb begin
        sel = '0;
        for (int i = 0; i < F_COUNT; i++) begin
            if (idx_q == IDX_W'(i)) sel[i] = 1'b1;
        end
    end

    // Next-state, strobes and field capture.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dly_d    = dly_q;
        to_d     = to_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        fn_d     = fn_q;
        bme_d    = bme_q;
        ext_d    = ext_q;
        mrrs_d   = mrrs_q;
        mps_d    = mps_q;
        speed_d  = speed_q;
        width_d  = width_q;
        valid_d  = valid_q;
        tcnt_d   = tcnt_q;
        end_poll = 1'b0;
        end_ok   = 1'b0;
`ifdef PCIE_US_CFG_POLL_WRITE_EN
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        ack_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef PCIE_US_CFG_POLL_WRITE_EN
                // ack_q blocks re-launching the request just acknowledged.
                if (wr_req && !ack_q) begin
                    wr_d    = 1'b1;
                    addr_d  = wr_addr;
                    fn_d    = wr_func;
                    wdata_d = wr_data;
                    be_d    = wr_be;
                    to_d    = TO_LOAD;
                    state_d = ST_WR;
                end else
`endif
                if (dly_q == '0) begin
                    rd_d    = 1'b1;
                    addr_d  = ADDR_CMD;
                    fn_d    = func_num(idx_q);
                    to_d    = TO_LOAD;
                    state_d = ST_RD_CMD;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ST_RD_CMD, ST_RD_DEVCTRL, ST_RD_LINK: begin
                if (!rd_q) begin
                    rd_d   = 1'b1;
                    addr_d = (state_q == ST_RD_LINK) ? ADDR_LINK : ADDR_DEVCTRL;
                    to_d   = TO_LOAD;
                end else if (cfg_mgmt_read_write_done) begin
                    rd_d = 1'b0;
                    case (state_q)
                        ST_RD_CMD: begin
                            for (int i = 0; i < F_COUNT; i++) begin
                                if (sel[i]) bme_d[i] = cfg_mgmt_read_data[2];
                            end
                            state_d = ST_RD_DEVCTRL;
                        end
                        ST_RD_DEVCTRL: begin
                            for (int i = 0; i < F_COUNT; i++) begin
                                if (sel[i]) begin
                                    ext_d[i]         = cfg_mgmt_read_data[8];
                                    mrrs_d[i*3 +: 3] = cfg_mgmt_read_data[14:12];
                                    mps_d[i*3 +: 3]  = cfg_mgmt_read_data[7:5];
                                end
                            end
                            if (READ_LINK_STATUS != 0 && idx_q == '0) begin
                                state_d = ST_RD_LINK;
                            end else begin
                                end_poll = 1'b1;
                                end_ok   = 1'b1;
                            end
                        end
                        default: begin
                            speed_d  = cfg_mgmt_read_data[19:16];
                            width_d  = cfg_mgmt_read_data[25:20];
                            end_poll = 1'b1;
                            end_ok   = 1'b1;
                        end
                    endcase
                end else if (to_q == '0) begin
                    // Abandon the rest of this function's reads.
                    rd_d = 1'b0;
                    if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
                    end_poll = 1'b1;
                end else begin
                    to_d = to_q - TO_W'(1);
                end
            end
`ifdef PCIE_US_CFG_POLL_WRITE_EN
            ST_WR: begin
                // Delay counter is left untouched so a due poll starts right after.
                if (cfg_mgmt_read_write_done) begin
                    wr_d    = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (to_q == '0) begin
                    wr_d    = 1'b0;
                    ack_d   = 1'b1;
                    if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
                    state_d = ST_IDLE;
                end else begin
                    to_d = to_q - TO_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (end_poll) begin
            state_d = ST_IDLE;
            dly_d   = DLY_LOAD;
            idx_d   = (idx_q == IDX_W'(F_COUNT - 1)) ? '0 : idx_q + IDX_W'(1);
            if (end_ok) valid_d = valid_q | sel;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dly_q   <= DLY_LOAD;
            to_q    <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            fn_q    <= '0;
            bme_q   <= '0;
            ext_q   <= '0;
            mrrs_q  <= '0;
            mps_q   <= '0;
            speed_q <= '0;
            width_q <= '0;
            valid_q <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            to_q    <= to_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            fn_q    <= fn_d;
            bme_q   <= bme_d;
            ext_q   <= ext_d;
            mrrs_q  <= mrrs_d;
            mps_q   <= mps_d;
            speed_q <= speed_d;
            width_q <= width_d;
            valid_q <= valid_d;
            tcnt_q  <= tcnt_d;
        end
    end

`ifdef PCIE_US_CFG_POLL_WRITE_EN
    // Host write strobe, payload and acknowledge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            ack_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ack_q   <= ack_d;
        end
    end

    assign cfg_mgmt_write       = wr_q;
    assign cfg_mgmt_write_data  = wdata_q;
    assign cfg_mgmt_byte_enable = be_q;
    assign wr_ack               = ack_q;
`else
    assign cfg_mgmt_write       = 1'b0;
    assign cfg_mgmt_write_data  = '0;
    assign cfg_mgmt_byte_enable = '0;
`endif

    assign cfg_mgmt_read            = rd_q;
    assign cfg_mgmt_addr            = addr_q;
    assign cfg_mgmt_function_number = fn_q;
    assign bus_master_enable        = bme_q;
    assign ext_tag_enable           = ext_q;
    assign max_read_request_size    = mrrs_q;
    assign max_payload_size         = mps_q;
    assign link_speed               = speed_q;
    assign link_width               = width_q;
    assign cfg_valid                = valid_q;
    assign timeout_count            = tcnt_q;

endmodule

// File: tb/tb_pcie_us_cfg_poll.sv
// Directed bench for pcie_us_cfg_poll with 2 PFs and 2 VFs (functions 0,1,64,65).
module tb_pcie_us_cfg_poll;

    localparam int         F     = 4;
    localparam logic [9:0] A_CMD = 10'h001;
    localparam logic [9:0] A_DEV = 10'h032;
    localparam logic [9:0] A_LNK = 10'h034;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [F-1:0]    ext_tag_enable;
    logic [F*3-1:0]  max_read_request_size;
    logic [F*3-1:0]  max_payload_size;
    logic [F-1:0]    bus_master_enable;
    logic [3:0]      link_speed;
    logic [5:0]      link_width;
    logic [F-1:0]    cfg_valid;
    logic [7:0]      timeout_count;
    logic [9:0]      cfg_mgmt_addr;
    logic [7:0]      cfg_mgmt_function_number;
    logic            cfg_mgmt_write;
    logic [31:0]     cfg_mgmt_write_data;
    logic [3:0]      cfg_mgmt_byte_enable;
    logic            cfg_mgmt_read;
    logic [31:0]     cfg_mgmt_read_data = '0;
    logic            cfg_mgmt_read_write_done = 1'b0;
`ifdef PCIE_US_CFG_POLL_WRITE_EN
    logic            wr_req = 1'b0;
    logic [7:0]      wr_func = '0;
    logic [9:0]      wr_addr = '0;
    logic [31:0]     wr_data = '0;
    logic [3:0]      wr_be = '0;
    logic            wr_ack;
`endif

    int   n_chk = 0;
    int   n_fail = 0;
    int   n;
    int   resp_cnt = 0;
    logic stall = 1'b0;
    logic spur = 1'b0;

    pcie_us_cfg_poll #(
        .PF_COUNT (2),
        .VF_COUNT (2)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
`ifdef PCIE_US_CFG_POLL_WRITE_EN
        .wr_req                   (wr_req),
        .wr_func                  (wr_func),
        .wr_addr                  (wr_addr),
        .wr_data                  (wr_data),
        .wr_be                    (wr_be),
        .wr_ack                   (wr_ack),
`endif
        .ext_tag_enable           (ext_tag_enable),
        .max_read_request_size    (max_read_request_size),
        .max_payload_size         (max_payload_size),
        .bus_master_enable        (bus_master_enable),
        .link_speed               (link_speed),
        .link_width               (link_width),
        .cfg_valid                (cfg_valid),
        .timeout_count            (timeout_count),
        .cfg_mgmt_addr            (cfg_mgmt_addr),
        .cfg_mgmt_function_number (cfg_mgmt_function_number),
        .cfg_mgmt_write           (cfg_mgmt_write),
        .cfg_mgmt_write_data      (cfg_mgmt_write_data),
        .cfg_mgmt_byte_enable     (cfg_mgmt_byte_enable),
        .cfg_mgmt_read            (cfg_mgmt_read),
        .cfg_mgmt_read_data       (cfg_mgmt_read_data),
        .cfg_mgmt_read_write_done (cfg_mgmt_read_write_done)
    );

    initial forever #5 clk = ~clk;

    // Config space contents seen by the poller.
    function automatic logic [31:0] cfg_data(input logic [7:0] f, input logic [9:0] a);
        logic [31:0] r;
        r = '0;
        case (f)
            8'd0:  r = (a == A_CMD) ? 32'h0000_0004 : (a == A_DEV) ? 32'h0000_2130 :
                       (a == A_LNK) ? 32'h0041_0000 : 32'h0;
            8'd1:  r = (a == A_CMD) ? 32'h0000_0004 : (a == A_DEV) ? 32'h0000_5040 : 32'h0;
            8'd64: r = (a == A_CMD) ? 32'h0000_0006 : (a == A_DEV) ? 32'h0000_3100 : 32'h0;
            8'd65: r = (a == A_CMD) ? 32'h0000_0003 : (a == A_DEV) ? 32'h0000_00E0 : 32'h0;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Completer: done two cycles after a strobe rises, unless stalled.
    initial forever begin
        @(negedge clk);
        if (spur) begin
            cfg_mgmt_read_write_done = 1'b1;
            cfg_mgmt_read_data = 32'hFFFF_FFFF;
        end else if (cfg_mgmt_read || cfg_mgmt_write) begin
            resp_cnt++;
            if (resp_cnt == 2 && !(stall && cfg_mgmt_function_number == 8'd1 && cfg_mgmt_addr == A_DEV)) begin
                cfg_mgmt_read_write_done = 1'b1;
                cfg_mgmt_read_data = cfg_data(cfg_mgmt_function_number, cfg_mgmt_addr);
            end else begin
                cfg_mgmt_read_write_done = 1'b0;
            end
        end else begin
            resp_cnt = 0;
            cfg_mgmt_read_write_done = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        n_chk++;
        n_fail++;
        $error("FAIL %s: event not seen within bound", tag);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    // Counts clocks until cfg_mgmt_read is seen rising.
    task automatic wait_rise(input string tag, output int k);
        logic prev;
        logic seen;
        prev = cfg_mgmt_read;
        seen = 1'b0;
        k = 0;
        while (!seen) begin
            @(posedge clk);
            #1;
            k++;
            if (!prev && cfg_mgmt_read) seen = 1'b1;
            prev = cfg_mgmt_read;
            if (!seen && k >= 3000) bound_fail(tag);
        end
    endtask

    task automatic rise_chk(input string tag, input int exp_n, input logic [9:0] exp_a,
                            input logic [7:0] exp_f);
        int k;
        wait_rise(tag, k);
        chk({tag, "_gap"}, 32'(k), 32'(exp_n));
        chk({tag, "_addr"}, 32'(cfg_mgmt_addr), 32'(exp_a));
        chk({tag, "_func"}, 32'(cfg_mgmt_function_number), 32'(exp_f));
    endtask

    task automatic fields_chk(input string tag, input logic [3:0] bme, input logic [3:0] ext,
                              input logic [11:0] mrrs, input logic [11:0] mps,
                              input logic [3:0] vld, input logic [7:0] tc);
        chk({tag, "_bme"}, 32'(bus_master_enable), 32'(bme));
        chk({tag, "_ext"}, 32'(ext_tag_enable), 32'(ext));
        chk({tag, "_mrrs"}, 32'(max_read_request_size), 32'(mrrs));
        chk({tag, "_mps"}, 32'(max_payload_size), 32'(mps));
        chk({tag, "_valid"}, 32'(cfg_valid), 32'(vld));
        chk({tag, "_tcnt"}, 32'(timeout_count), 32'(tc));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        fields_chk("rst", 4'h0, 4'h0, 12'h0, 12'h0, 4'h0, 8'h0);
        chk("rst_read", 32'(cfg_mgmt_read), 32'h0);
        chk("rst_addr", 32'(cfg_mgmt_addr), 32'h0);
        chk("rst_func", 32'(cfg_mgmt_function_number), 32'h0);
        chk("rst_speed", 32'(link_speed), 32'h0);
        chk("rst_width", 32'(link_width), 32'h0);
        chk("rst_write", 32'(cfg_mgmt_write), 32'h0);
        chk("rst_wdata", cfg_mgmt_write_data, 32'h0);
        chk("rst_be", 32'(cfg_mgmt_byte_enable), 32'h0);

        // Round 1: function 1 Device Control is never completed.
        @(negedge clk);
        rst_n = 1'b1;
        rise_chk("r1_f0_cmd", 256, A_CMD, 8'd0);
        rise_chk("r1_f0_dev", 3, A_DEV, 8'd0);
        rise_chk("r1_f0_lnk", 3, A_LNK, 8'd0);
        rise_chk("r1_f1_cmd", 258, A_CMD, 8'd1);
        chk("f0_speed", 32'(link_speed), 32'd1);
        chk("f0_width", 32'(link_width), 32'd4);
        fields_chk("f0", 4'b0001, 4'b0001, 12'h002, 12'h001, 4'b0001, 8'd0);

        stall = 1'b1;
        rise_chk("r1_f1_dev", 3, A_DEV, 8'd1);
        n = 0;
        while (cfg_mgmt_read && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("timeout_len", 32'(n), 32'd1024);
        fields_chk("to", 4'b0011, 4'b0001, 12'h002, 12'h001, 4'b0001, 8'd1);
        stall = 1'b0;

        rise_chk("r1_f64_cmd", 256, A_CMD, 8'd64);
        rise_chk("r1_f64_dev", 3, A_DEV, 8'd64);
        rise_chk("r1_f65_cmd", 258, A_CMD, 8'd65);
        rise_chk("r1_f65_dev", 3, A_DEV, 8'd65);
        rise_chk("r2_f0_cmd", 258, A_CMD, 8'd0);
        fields_chk("r1", 4'b0111, 4'b0101, 12'h0C2, 12'hE01, 4'b1101, 8'd1);

        // Round 2, with a spurious done while idle after function 0.
        rise_chk("r2_f0_dev", 3, A_DEV, 8'd0);
        rise_chk("r2_f0_lnk", 3, A_LNK, 8'd0);
        repeat (10) @(posedge clk);
        spur = 1'b1;
        @(posedge clk);
        spur = 1'b0;
        @(posedge clk);
        #1;
        chk("spur_read", 32'(cfg_mgmt_read), 32'h0);
        chk("spur_speed", 32'(link_speed), 32'd1);
        chk("spur_width", 32'(link_width), 32'd4);
        fields_chk("spur", 4'b0111, 4'b0101, 12'h0C2, 12'hE01, 4'b1101, 8'd1);
        rise_chk("r2_f1_cmd", 246, A_CMD, 8'd1);
        rise_chk("r2_f1_dev", 3, A_DEV, 8'd1);
        rise_chk("r2_f64_cmd", 258, A_CMD, 8'd64);
        fields_chk("r2", 4'b0111, 4'b0101, 12'h0EA, 12'hE11, 4'b1111, 8'd1);

        // Reset while the function 64 Device Control read is outstanding.
        rise_chk("r2_f64_dev", 3, A_DEV, 8'd64);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_read", 32'(cfg_mgmt_read), 32'h0);
        chk("mid_rst_addr", 32'(cfg_mgmt_addr), 32'h0);
        chk("mid_rst_func", 32'(cfg_mgmt_function_number), 32'h0);
        chk("mid_rst_speed", 32'(link_speed), 32'h0);
        chk("mid_rst_width", 32'(link_width), 32'h0);
        fields_chk("mid_rst", 4'h0, 4'h0, 12'h0, 12'h0, 4'h0, 8'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rise_chk("restart_cmd", 256, A_CMD, 8'd0);

`ifdef PCIE_US_CFG_POLL_WRITE_EN
        // Host write arriving on the same edge the poll interval expires.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (255) @(posedge clk);
        #1;
        wr_func = 8'd0;
        wr_addr = 10'h032;
        wr_data = 32'h0000_2850;
        wr_be   = 4'hF;
        wr_req  = 1'b1;
        @(posedge clk);
        #1;
        chk("wr_strobe", 32'(cfg_mgmt_write), 32'h1);
        chk("wr_no_read", 32'(cfg_mgmt_read), 32'h0);
        chk("wr_addr", 32'(cfg_mgmt_addr), 32'h032);
        chk("wr_func", 32'(cfg_mgmt_function_number), 32'h0);
        chk("wr_data", cfg_mgmt_write_data, 32'h0000_2850);
        chk("wr_be", 32'(cfg_mgmt_byte_enable), 32'hF);
        n = 0;
        while (!wr_ack && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wr_ack_lat", 32'(n), 32'd2);
        chk("wr_strobe_low", 32'(cfg_mgmt_write), 32'h0);
        wr_req = 1'b0;
        @(posedge clk);
        #1;
        chk("wr_ack_pulse", 32'(wr_ack), 32'h0);
        chk("wr_poll_read", 32'(cfg_mgmt_read), 32'h1);
        chk("wr_poll_addr", 32'(cfg_mgmt_addr), 32'(A_CMD));
        chk("wr_poll_func", 32'(cfg_mgmt_function_number), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_us_cfg_poll.md
Name: pcie_us_cfg_poll

Overview:
Parametrised PCIe config-space poller for UltraScale cfg_mgmt interface; successor to the single-register device-control shim. It round-robins over all PF/VF functions and reads Command, Device Control and (PF0) Link Status. It exports per-function bus-master enable, ext tag, MRRS and MPS, plus PF0 negotiated link speed/width. It adds a configurable poll interval, a read-completion timeout, per-function valid flags and error counting. Sits between the PCIe hard IP cfg_mgmt port and DMA/TLP engines.

Parameters:
PF_COUNT, 1, number of physical functions (1-8)
VF_COUNT, 0, number of virtual functions
VF_OFFSET, 64, cfg_mgmt function number of first VF
F_COUNT, PF_COUNT+VF_COUNT, total functions polled
PCIE_CAP_OFFSET, 12'h0C0, byte offset of PCIe capability
POLL_INTERVAL, 256, idle cycles between function polls (>=2)
TIMEOUT, 1024, cycles to wait for cfg_mgmt_read_write_done before abort (>=4)
READ_LINK_STATUS, 1, 1 = read Link Control/Status for function index 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ext_tag_enable  out  F_COUNT  Device Control bit 8 per function
max_read_request_size  out  F_COUNT*3  Device Control [14:12] per function
max_payload_size  out  F_COUNT*3  Device Control [7:5] per function
bus_master_enable  out  F_COUNT  Command bit 2 per function
link_speed  out  4  PF0 Link Status [19:16]
link_width  out  6  PF0 Link Status [25:20]
cfg_valid  out  F_COUNT  set after first complete error-free poll of function
timeout_count  out  8  saturating count of timed-out reads
cfg_mgmt_addr  out  10  dword address
cfg_mgmt_function_number  out  8  target function
cfg_mgmt_write  out  1  write strobe
cfg_mgmt_write_data  out  32  write data
cfg_mgmt_byte_enable  out  4  byte enables
cfg_mgmt_read  out  1  read strobe
cfg_mgmt_read_data  in  32  read data
cfg_mgmt_read_write_done  in  1  completion

Behaviour:
- Reset (async, rst_n=0): every output 0; state IDLE; func index 0; delay counter = POLL_INTERVAL-1; timeout counter 0. Reset mid-read drops cfg_mgmt_read immediately; no field updated.
- Function mapping: index i<PF_COUNT -> function i; else VF_OFFSET+(i-PF_COUNT), 8-bit.
- States: IDLE -> RD_CMD -> RD_DEVCTRL -> [RD_LINK if READ_LINK_STATUS and index==0] -> IDLE.
- IDLE: decrement delay each cycle; at 0 register addr=1 (byte 0x004), function number, read=1, enter RD_CMD. First cfg_mgmt_read rises POLL_INTERVAL cycles after rst_n deassert.
- Read states: read held high until done. On done: capture fields same cycle, read low next cycle, next state issues next read the following cycle (1 idle cycle between strobes). RD_DEVCTRL addr=(PCIE_CAP_OFFSET+8)>>2; RD_LINK addr=(PCIE_CAP_OFFSET+16)>>2.
- Timeout: per-read counter; done not seen within TIMEOUT cycles -> drop read, timeout_count+1 (saturate 255), mark function's poll bad, skip remaining reads of that function, go IDLE.
- End of function poll: cfg_valid[i] set if all its reads completed; never cleared except reset. Index advances, wraps F_COUNT-1 -> 0; delay reloads POLL_INTERVAL-1.
- done while no read/write outstanding: ignored. cfg_mgmt_write constant 0 and byte_enable/write_data 0 unless feature enabled.

Optional Feature:
Macro PCIE_US_CFG_POLL_WRITE_EN. When defined: extra ports wr_req(in,1), wr_func(in,8), wr_addr(in,10), wr_data(in,32), wr_be(in,4), wr_ack(out,1). In IDLE a pending wr_req has priority over starting a poll: drives write strobe with registered fields, holds until done (or timeout, counted), pulses wr_ack one cycle, returns IDLE without reloading delay. Requester holds wr_req/fields until wr_ack. Without macro: ports absent, write outputs tied 0.

Test Plan:
- Reset release, PF_COUNT=1, done 2 cycles after each read, data Cmd=0x0000_0004, DevCtrl=0x0000_2130, Link=0x0041_0000 -> first read at cycle 256; bus_master_enable=1, ext_tag=1, MRRS=2, MPS=1, link_speed=1, link_width=4, cfg_valid=1.
- PF_COUNT=2, VF_COUNT=2 -> function numbers sequence 0,1,64,65,0; per-function fields land in correct slices.
- Never assert done on function 1 DevCtrl -> read dropped after 1024 cycles, timeout_count=1, cfg_valid[1]=0, poll proceeds to function 64.
- rst_n low during RD_DEVCTRL -> cfg_mgmt_read low immediately, all outputs 0, restart after POLL_INTERVAL.
- Spurious done in IDLE -> no field change, no state change.
- With PCIE_US_CFG_POLL_WRITE_EN: wr_req (func 0, addr 0x32, data 0x0000_2850, be 0xF) concurrent with delay expiry -> write issued first, wr_ack one cycle, poll follows.
